// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor sequencer: FSM state
// encodings and the default operand width.
package serial_sub_ctrl_pkg;

  // Sequencer states; encodings are fixed so waveforms match the datapath docs.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Default operand/result width.
  localparam int SUB_W = 8;

endpackage

// File: rtl/serial_sub_ctrl_full_sub_bit.sv
// 1-bit full subtractor (d = x - y - bi, bo = borrow out), built from two
// half-subtractor cells plus an OR gate, using the same xor/and/not gate
// structure as the standalone half-subtractor cells.
module full_sub_bit (
  output logic d,
  output logic bo,
  input  logic x,
  input  logic y,
  input  logic bi
);

  logic hd1_s;   // first half-subtractor difference: x ^ y
  logic nx_s;    // ~x
  logic hb1_s;   // first half-subtractor borrow: ~x & y
  logic nhd1_s;  // ~(x ^ y)
  logic hb2_s;   // second half-subtractor borrow: ~(x ^ y) & bi

  // First half subtractor: x - y
  xor g_hd1  (hd1_s, x, y);
  not g_nx   (nx_s, x);
  and g_hb1  (hb1_s, nx_s, y);

  // Second half subtractor: (x ^ y) - bi
  xor g_d    (d, hd1_s, bi);
  not g_nhd1 (nhd1_s, hd1_s);
  and g_hb2  (hb2_s, nhd1_s, bi);

  // Either half stage borrowing produces the outgoing borrow
  or  g_bo   (bo, hb1_s, hb2_s);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial W-bit subtractor sequencer: computes a-b one bit per clock,
// LSB first, through a single full_sub_bit cell with the borrow held in a
// flip-flop. start/done handshake; one result every W+2 cycles.
// Optional feature: define SUB_SIGNED_OVF_EN to add the signed-overflow
// output ovf. With it undefined the port and its logic are absent.
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int W     = SUB_W,
  parameter int CNT_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         borrow_out
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state_r;
  logic [W-1:0]       sa_r;    // minuend shift register
  logic [W-1:0]       sb_r;    // subtrahend shift register
  logic [W-1:0]       res_r;   // result shift register, filled from the MSB
  logic [CNT_W-1:0]   cnt_r;   // index of the bit being processed
  logic               bff_r;   // borrow carried between bit slices
  logic               d_s;
  logic               bo_s;
`ifdef SUB_SIGNED_OVF_EN
  logic               a_msb_r; // operand sign bits, captured at load
  logic               b_msb_r;
`endif

  full_sub_bit u_cell (
    .d  (d_s),
    .bo (bo_s),
    .x  (sa_r[0]),
    .y  (sb_r[0]),
    .bi (bff_r)
  );

  // Sequencer FSM with all datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      sa_r       <= '0;
      sb_r       <= '0;
      res_r      <= '0;
      cnt_r      <= '0;
      bff_r      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
      a_msb_r    <= 1'b0;
      b_msb_r    <= 1'b0;
      ovf        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            sa_r    <= a;
            sb_r    <= b;
            bff_r   <= 1'b0;
            cnt_r   <= '0;
            busy    <= 1'b1;
            state_r <= ST_RUN;
`ifdef SUB_SIGNED_OVF_EN
            a_msb_r <= a[W-1];
            b_msb_r <= b[W-1];
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          bff_r <= bo_s;
          sa_r  <= {1'b0, sa_r[W-1:1]};
          sb_r  <= {1'b0, sb_r[W-1:1]};
          res_r <= {d_s, res_r[W-1:1]};
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == LAST_BIT) begin
            busy    <= 1'b0;
            state_r <= ST_FIN;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_FIN: begin
          diff       <= res_r;
          borrow_out <= bff_r;
          done       <= 1'b1;
          state_r    <= ST_IDLE;
`ifdef SUB_SIGNED_OVF_EN
          ovf        <= (a_msb_r ^ b_msb_r) & (a_msb_r ^ res_r[W-1]);
`endif
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed self-checking bench for serial_sub_ctrl: an 8-bit instance for
// the handshake/latency/reset scenarios and a 4-bit instance for an
// exhaustive back-to-back sweep.
module tb_serial_sub_ctrl;

  logic       clk = 1'b0;
  logic       rst8, rst4;
  logic       start8, start4;
  logic [7:0] a8, b8, diff8;
  logic [3:0] a4, b4, diff4;
  logic       busy8, done8, bor8;
  logic       busy4, done4, bor4;
`ifdef SUB_SIGNED_OVF_EN
  logic       ovf8, ovf4;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.W(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bor8)
`ifdef SUB_SIGNED_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_sub_ctrl #(.W(4), .CNT_W(3)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bor4)
`ifdef SUB_SIGNED_OVF_EN
    , .ovf(ovf4)
`endif
  );

  // Issue a one-cycle start on the 8-bit DUT; returns at the negedge after the accepting edge.
  task automatic start_op8(input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    a8 = av; b8 = bv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Wait (bounded) for done8; cyc = negedges waited, -1 on timeout.
  task automatic wait_done8(output int cyc);
    cyc = 0;
    while (!done8 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!done8) cyc = -1;
  endtask

  task automatic test_reset;
    rst8 = 1'b1; rst4 = 1'b1; start8 = 1'b0; start4 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; a4 = 4'h0; b4 = 4'h0;
    repeat (3) @(negedge clk);
    rst8 = 1'b0; rst4 = 1'b0;
    @(negedge clk);
    n_total++;
    if ({busy8, done8, bor8, diff8} !== {1'b0, 1'b0, 1'b0, 8'h00})
      $display("FAIL reset8: busy=%b done=%b borrow=%b diff=%h, want 0/0/0/00", busy8, done8, bor8, diff8);
    else n_pass++;
    n_total++;
    if ({busy4, done4, bor4, diff4} !== {1'b0, 1'b0, 1'b0, 4'h0})
      $display("FAIL reset4: busy=%b done=%b borrow=%b diff=%h, want 0/0/0/0", busy4, done4, bor4, diff4);
    else n_pass++;
`ifdef SUB_SIGNED_OVF_EN
    n_total++;
    if (ovf8 !== 1'b0) $display("FAIL reset_ovf: ovf=%b want 0", ovf8);
    else n_pass++;
`endif
  endtask

  // a=5, b=3: busy exactly 8 cycles, done one cycle after FIN, diff stable during RUN.
  task automatic test_basic;
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at  = -1;
    logic diff_moved = 1'b0;
    start_op8(8'd5, 8'd3);
    for (int k = 0; k < 14; k++) begin
      if (busy8) busy_cnt++;
      if (done8) begin done_cnt++; done_at = k; end
      if (k < 9 && diff8 !== 8'h00) diff_moved = 1'b1;
      @(negedge clk);
    end
    n_total++;
    if (busy_cnt !== 8) $display("FAIL basic_busy_len: got %0d want 8", busy_cnt);
    else n_pass++;
    n_total++;
    if (done_cnt !== 1 || done_at !== 9)
      $display("FAIL basic_done: count=%0d at=%0d want 1 at 9", done_cnt, done_at);
    else n_pass++;
    n_total++;
    if (diff_moved !== 1'b0) $display("FAIL basic_hold: diff changed before done");
    else n_pass++;
    n_total++;
    if ({diff8, bor8} !== {8'h02, 1'b0})
      $display("FAIL basic_result: diff=%h borrow=%b want 02/0", diff8, bor8);
    else n_pass++;
  endtask

  task automatic test_neg;
    int cyc;
    start_op8(8'd3, 8'd5);
    wait_done8(cyc);
    n_total++;
    if (cyc !== 9) $display("FAIL neg_latency: got %0d want 9", cyc);
    else n_pass++;
    n_total++;
    if ({diff8, bor8} !== {8'hFE, 1'b1})
      $display("FAIL neg_result: diff=%h borrow=%b want FE/1", diff8, bor8);
    else n_pass++;
`ifdef SUB_SIGNED_OVF_EN
    n_total++;
    if (ovf8 !== 1'b0) $display("FAIL neg_ovf: ovf=%b want 0", ovf8);
    else n_pass++;
`endif
  endtask

  task automatic test_signed_edge;
    int cyc;
    start_op8(8'h80, 8'h01);
    wait_done8(cyc);
    n_total++;
    if (cyc !== 9 || {diff8, bor8} !== {8'h7F, 1'b0})
      $display("FAIL ovf_case_result: cyc=%0d diff=%h borrow=%b want 9/7F/0", cyc, diff8, bor8);
    else n_pass++;
`ifdef SUB_SIGNED_OVF_EN
    n_total++;
    if (ovf8 !== 1'b1) $display("FAIL ovf_case_ovf: ovf=%b want 1", ovf8);
    else n_pass++;
`endif
  endtask

  // 0-1 with stray start pulses while busy: exactly one done.
  task automatic test_start_ignored;
    int done_cnt = 0;
    start_op8(8'h00, 8'h01);
    repeat (3) @(negedge clk);
    start8 = 1'b1; a8 = 8'h44; b8 = 8'h11;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (done8) done_cnt++;
      @(negedge clk);
    end
    n_total++;
    if (done_cnt !== 1) $display("FAIL ignore_done_count: got %0d want 1", done_cnt);
    else n_pass++;
    n_total++;
    if ({diff8, bor8} !== {8'hFF, 1'b1})
      $display("FAIL ignore_result: diff=%h borrow=%b want FF/1", diff8, bor8);
    else n_pass++;
  endtask

  // Reset during RUN bit 4 aborts with no done; next op works.
  task automatic test_mid_reset;
    int done_cnt = 0;
    int cyc;
    start_op8(8'h55, 8'h0F);
    repeat (4) @(negedge clk);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    n_total++;
    if ({busy8, done8, bor8, diff8} !== {1'b0, 1'b0, 1'b0, 8'h00})
      $display("FAIL midrst_state: busy=%b done=%b borrow=%b diff=%h want 0/0/0/00", busy8, done8, bor8, diff8);
    else n_pass++;
    for (int k = 0; k < 15; k++) begin
      if (done8 || busy8) done_cnt++;
      @(negedge clk);
    end
    n_total++;
    if (done_cnt !== 0) $display("FAIL midrst_no_done: activity cycles=%0d want 0", done_cnt);
    else n_pass++;
    start_op8(8'd9, 8'd9);
    wait_done8(cyc);
    n_total++;
    if (cyc !== 9 || {diff8, bor8} !== {8'h00, 1'b0})
      $display("FAIL midrst_next: cyc=%0d diff=%h borrow=%b want 9/00/0", cyc, diff8, bor8);
    else n_pass++;
  endtask

  // Exhaustive 4-bit sweep with start held high: back-to-back every 6 cycles.
  task automatic test_back_to_back;
    int cyc;
    int errs = 0;
    logic [3:0] ea, eb, exp_d;
    @(negedge clk);
    a4 = 4'h0; b4 = 4'h0; start4 = 1'b1;
    for (int idx = 0; idx < 256; idx++) begin
      ea = 4'(idx >> 4);
      eb = 4'(idx);
      exp_d = ea - eb;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!done4 && cyc < 20);
      n_total++;
      if (cyc !== 6) begin
        if (errs < 10) $display("FAIL b2b_spacing: a=%h b=%h cyc=%0d want 6", ea, eb, cyc);
        errs++;
      end else n_pass++;
      n_total++;
      if (diff4 !== exp_d || bor4 !== (ea < eb)) begin
        if (errs < 10) $display("FAIL b2b_result: a=%h b=%h diff=%h borrow=%b want %h/%b", ea, eb, diff4, bor4, exp_d, ea < eb);
        errs++;
      end else n_pass++;
      if (idx < 255) begin
        a4 = 4'((idx + 1) >> 4);
        b4 = 4'(idx + 1);
      end else begin
        start4 = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_neg();
    test_signed_edge();
    test_start_ignored();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
